// File: rtl/sd_gap_reporter.sv
// sd_gap_reporter
// Measures the number of idle cycles between detection pulses and queues each
// measurement in a small first-word-fall-through FIFO. It also keeps a
// saturating count of all detections and a sticky flag for dropped reports.
module sd_gap_reporter #(
    parameter int GAP_W = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             clr,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [GAP_W-1:0] out_gap,
    output logic [CNT_W-1:0] total_cnt,
    output logic             fifo_full,
    output logic             overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [GAP_W-1:0] gap_cnt;
    logic [GAP_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [CNT_W-1:0] tot;
    logic             ovf;

    logic push;
    logic pop;
    logic full;
    logic wr_en;
    logic drop;

    // Saturating increment for the idle-gap counter.
    function automatic logic [GAP_W-1:0] sat_inc_gap(input logic [GAP_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Saturating increment for the total detection counter.
    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // A clear cancels both the push and the pop of its cycle.
    assign full  = (count == FULL_CNT);
    assign push  = din & ~clr;
    assign pop   = (count != '0) & out_ready & ~clr;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign wr_en = push & (~full | pop);
    assign drop  = push & full & ~pop;

    // Control state: gap counter, detection total, pointers, occupancy, sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap_cnt <= '0;
            tot     <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ovf     <= 1'b0;
        end else if (clr) begin
            gap_cnt <= '0;
            tot     <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ovf     <= 1'b0;
        end else begin
            gap_cnt <= din ? '0 : sat_inc_gap(gap_cnt);
            if (din) begin
                tot <= sat_inc_cnt(tot);
            end
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) begin
                ovf <= 1'b1;
            end
        end
    end

    // Report storage; entries need no reset because occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= gap_cnt;
        end
    end

    assign out_valid = (count != '0);
    assign out_gap   = mem[rd_ptr];
    assign fifo_full = full;
    assign total_cnt = tot;
    assign overflow  = ovf;

endmodule

// File: tb/tb_sd_gap_reporter.sv
// Testbench for sd_gap_reporter: directed stimulus pushes hand-computed gap
// reports into a scoreboard queue; a monitor pops them as the DUT hands them out.
module tb_sd_gap_reporter;

    logic       clk;
    logic       rst;
    logic       din;
    logic       clr;
    logic       out_ready;
    logic       out_valid;
    logic [7:0] out_gap;
    logic [15:0] total_cnt;
    logic       fifo_full;
    logic       overflow;

    int n_run;
    int n_fail;

    int exp_q[$];

    logic e_valid;
    logic e_full;
    logic e_ovf;
    int   e_total;
    int   req_id;
    int   seen_id;
    string req_name;

    sd_gap_reporter #(
        .GAP_W(8),
        .DEPTH(4),
        .CNT_W(16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .clr       (clr),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_gap   (out_gap),
        .total_cnt (total_cnt),
        .fifo_full (fifo_full),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor-side comparison; only the monitor touches the counters.
    task automatic chk(input string name, input int act, input int exp);
        n_run++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: compares popped reports and any pending status request.
    initial begin
        seen_id = 0;
        forever begin
            @(negedge clk);
            if (rst || clr) begin
                exp_q.delete();
            end else if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_run++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_pop: got gap %0d, expected no report", out_gap);
                end else begin
                    chk("pop_gap", int'(out_gap), exp_q.pop_front());
                end
            end
            if (req_id != seen_id) begin
                seen_id = req_id;
                chk({req_name, ".out_valid"}, int'(out_valid), int'(e_valid));
                chk({req_name, ".fifo_full"}, int'(fifo_full), int'(e_full));
                chk({req_name, ".overflow"},  int'(overflow),  int'(e_ovf));
                chk({req_name, ".total_cnt"}, int'(total_cnt), e_total);
            end
        end
    end

    // One clock cycle with the given inputs; returns just after the edge.
    task automatic drive(input logic d, input logic r);
        din = d;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    // Record an expected report for a push that will be accepted.
    task automatic expect_gap(input int g);
        exp_q.push_back(g);
    endtask

    // Ask the monitor to compare status outputs at the next falling edge.
    task automatic status(input string name, input logic v, input logic f,
                          input logic o, input int t);
        req_name = name;
        e_valid  = v;
        e_full   = f;
        e_ovf    = o;
        e_total  = t;
        req_id++;
    endtask

    // Synchronous clear, issued together with a detection and a ready consumer.
    task automatic do_clr();
        clr = 1'b1;
        din = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        din = 1'b0;
        out_ready = 1'b0;
    endtask

    // Bound on total run time.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        n_run = 0;
        n_fail = 0;
        req_id = 0;
        rst = 1'b1;
        din = 1'b0;
        clr = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        status("reset", 1'b0, 1'b0, 1'b0, 0);
        @(negedge clk);
        #1;
        rst = 1'b0;

        // Five idle cycles then one detection.
        repeat (5) drive(1'b0, 1'b1);
        expect_gap(5);
        drive(1'b1, 1'b1);
        status("first_event", 1'b1, 1'b0, 1'b0, 1);
        drive(1'b0, 1'b1);
        status("first_popped", 1'b0, 1'b0, 1'b0, 1);
        drive(1'b0, 1'b0);

        // Pattern 1,0,1,0,0,1,1,0,1 with no consumer.
        do_clr();
        expect_gap(0); drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        expect_gap(1); drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        expect_gap(2); drive(1'b1, 1'b0);
        expect_gap(0); drive(1'b1, 1'b0);
        status("four_pushed", 1'b1, 1'b1, 1'b0, 4);
        drive(1'b0, 1'b0);
        drive(1'b1, 1'b0);
        status("fifth_dropped", 1'b1, 1'b1, 1'b1, 5);
        repeat (4) drive(1'b0, 1'b1);
        status("drained", 1'b0, 1'b0, 1'b1, 5);
        drive(1'b0, 1'b0);

        // Push and pop together on a full FIFO.
        do_clr();
        expect_gap(0); drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        expect_gap(1); drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        expect_gap(2); drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        expect_gap(3); drive(1'b1, 1'b0);
        status("full_again", 1'b1, 1'b1, 1'b0, 4);
        drive(1'b0, 1'b0);
        expect_gap(1); drive(1'b1, 1'b1);
        status("full_push_pop", 1'b1, 1'b1, 1'b0, 5);
        repeat (4) drive(1'b0, 1'b1);
        status("drained2", 1'b0, 1'b0, 1'b0, 5);
        drive(1'b0, 1'b0);

        // Push and pop together on a single-entry FIFO.
        do_clr();
        drive(1'b0, 1'b0);
        expect_gap(1); drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        expect_gap(2); drive(1'b1, 1'b1);
        status("single_replace", 1'b1, 1'b0, 1'b0, 2);
        drive(1'b0, 1'b1);
        status("single_drained", 1'b0, 1'b0, 1'b0, 2);
        drive(1'b0, 1'b0);

        // Gap counter saturation, then a short gap.
        do_clr();
        repeat (300) drive(1'b0, 1'b1);
        expect_gap(255); drive(1'b1, 1'b1);
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b1);
        expect_gap(2); drive(1'b1, 1'b1);
        drive(1'b0, 1'b1);
        status("sat_done", 1'b0, 1'b0, 1'b0, 2);
        drive(1'b0, 1'b0);

        // Three queued reports with overflow, then asynchronous reset mid-cycle.
        do_clr();
        repeat (4) begin
            expect_gap(0);
            drive(1'b1, 1'b0);
        end
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b1);
        status("three_queued", 1'b1, 1'b0, 1'b1, 5);
        drive(1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        status("async_reset", 1'b0, 1'b0, 1'b0, 0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        repeat (3) drive(1'b0, 1'b1);
        status("after_reset", 1'b0, 1'b0, 1'b0, 0);
        drive(1'b0, 1'b0);

        // Same state again, removed by clr with a simultaneous detection and ready.
        do_clr();
        repeat (4) begin
            expect_gap(0);
            drive(1'b1, 1'b0);
        end
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b1);
        status("three_queued2", 1'b1, 1'b0, 1'b1, 5);
        drive(1'b0, 1'b0);
        do_clr();
        status("after_clr", 1'b0, 1'b0, 1'b0, 0);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        expect_gap(3); drive(1'b1, 1'b1);
        drive(1'b0, 1'b1);
        status("first_after_clr", 1'b0, 1'b0, 1'b0, 1);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
